piso_tx_scheduler: RTL

Round-robin transmit scheduler that shares one 32-bit parallel-in/serial-out shift register among several requesters. It accepts a parallel word from one requester per frame using a valid/ready handshake, loads it into the shift core, and sequences the shift one bit per `Bit_Tick_In`, MSB first. A programmable idle gap follows every frame. It sits between the word-producing blocks and the single serial output line.

---
 rtl/piso_tx_pkg.sv | 24 ++
 rtl/piso_shift_core.sv | 28 ++
 rtl/piso_tx_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and width helpers for the round-robin PISO transmit scheduler.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } piso_tx_state_t;

  // Bit counter holds DATA_WIDTH-1 down to 0.
  function automatic int bit_cnt_w(input int data_width);
    return (data_width > 2) ? $clog2(data_width) : 1;
  endfunction

  // Gap counter holds GAP_CYCLES-1 down to 0; keep at least one bit when the gap is 0 or 1.
  function automatic int gap_cnt_w(input int gap_cycles);
    return (gap_cycles > 2) ? $clog2(gap_cycles) : 1;
  endfunction

  function automatic int grant_w(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// DATA_WIDTH-bit parallel-in/serial-out register, MSB first, load wins over shift.
module piso_shift_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Load_In,
  input  logic                  Shift_En_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  Serial_Data_Out
);

  logic [DATA_WIDTH-1:0] shift_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      shift_q <= '0;
    end else if (Load_In) begin
      shift_q <= Parallel_Data_In;
    end else if (Shift_En_In) begin
      shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign Serial_Data_Out = shift_q[DATA_WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin transmit scheduler: grants one requester per frame, shifts its word out
// MSB first on each bit tick, then idles for a fixed gap.
module piso_tx_scheduler
  import piso_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                            Clk_In,
  input  logic                            Reset_In,
  input  logic [NUM_REQ-1:0]              Req_Valid_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   Req_Data_In,
  output logic [NUM_REQ-1:0]              Req_Ready_Out,
  input  logic                            Bit_Tick_In,
  output logic                            Serial_Data_Out,
  output logic                            Serial_Valid_Out,
  output logic                            Frame_Last_Out,
  output logic [grant_w(NUM_REQ)-1:0]     Grant_Id_Out,
  output logic                            Busy_Out
);

  localparam int CNT_W = bit_cnt_w(DATA_WIDTH);
  localparam int GAP_W = gap_cnt_w(GAP_CYCLES);
  localparam int GNT_W = grant_w(NUM_REQ);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  piso_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [GNT_W-1:0]  last_grant_q;
  logic [GNT_W-1:0]  grant_q;

  logic [GNT_W-1:0]  winner;
  logic              any_valid;
  logic              load;
  logic              shift_en;
  logic              frame_last;
  logic              serial_valid;
  logic [NUM_REQ-1:0] ready;

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan upward from last_grant+1 with wrap; the first valid requester wins.
  always_comb begin : rr_arbiter
    logic [GNT_W-1:0] cand;
    cand      = last_grant_q;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GNT_W'(NUM_REQ - 1)) ? '0 : cand + GNT_W'(1);
      if (!any_valid && Req_Valid_In[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    shift_en     = 1'b0;
    frame_last   = 1'b0;
    serial_valid = 1'b0;
    ready        = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is combinational from the inputs, so hold it off while reset is asserted.
        if (any_valid && Reset_In) begin
          ready[winner] = 1'b1;
          load          = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        if (Bit_Tick_In) begin
          shift_en     = 1'b1;
          serial_valid = 1'b1;
          if (bit_cnt_q == '0) begin
            frame_last = 1'b1;
            state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= GNT_W'(NUM_REQ - 1);
      grant_q      <= '0;
    end else begin
      if (load) begin
        bit_cnt_q    <= CNT_LOAD;
        last_grant_q <= winner;
        grant_q      <= winner;
      end else if (shift_en && bit_cnt_q != '0) begin
        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
      end

      if (frame_last) begin
        gap_cnt_q <= GAP_LOAD;
      end else if (state_q == GAP && gap_cnt_q != '0) begin
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
    end
  end

  piso_shift_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_core (
    .Clk_In           (Clk_In),
    .Reset_In         (Reset_In),
    .Load_In          (load),
    .Shift_En_In      (shift_en),
    .Parallel_Data_In (req_word[winner]),
    .Serial_Data_Out  (Serial_Data_Out)
  );

  assign Req_Ready_Out    = ready;
  assign Serial_Valid_Out = serial_valid;
  assign Frame_Last_Out   = frame_last;
  assign Grant_Id_Out     = grant_q;
  assign Busy_Out         = (state_q != IDLE);

endmodule
